// File: rtl/tdm_bit_serializer.sv
// tdm_bit_serializer
//   Feeds the 1-to-4 bit demultiplexer. A parallel word tagged with a 2-bit
//   destination channel is taken over a valid/ready handshake and shifted out
//   one bit per clock on `data`. `Sel` carries the channel and is held for
//   the whole word, so every bit of that word lands on one demux output.
//   A one-cycle GAP after each word returns all demux outputs to 0.
//
// Parameters
//   WIDTH      payload bits per word (2..16)
//   LSB_FIRST  1: bit 0 leaves first, 0: bit WIDTH-1 leaves first
//   IDLE_CHAN  value of `Sel` out of reset
//
// Build option
//   TDM_SER_PARITY_EN  when defined, an even-parity bit (XOR of the payload)
//                      follows the payload on the same `Sel`, and `last`
//                      marks that parity bit instead of payload bit WIDTH-1.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    word to serialize
//   in_chan    destination channel (00=A, 01=B, 10=C, 11=D)
//   in_valid   word/channel presented
//   in_ready   word can be accepted this cycle (IDLE only)
//   data       serial bit to the demux
//   Sel        channel select to the demux
//   bit_valid  `data` carries a payload or parity bit
//   first      first bit of a word
//   last       final bit of a word
//   busy       word in flight
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a word; data=0, Sel holds last channel
// SHIFT | one payload bit per cycle, counter 0..WIDTH-1
// PARITY| even-parity bit of the word (only with TDM_SER_PARITY_EN)
// GAP   | one dead cycle, data=0, so demux outputs return to 0
module tdm_bit_serializer #(
  parameter int         WIDTH     = 8,
  parameter bit         LSB_FIRST = 1'b1,
  parameter logic [1:0] IDLE_CHAN = 2'b00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_chan,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data,
  output logic [1:0]       Sel,
  output logic             bit_valid,
  output logic             first,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef TDM_SER_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
`endif
  localparam logic [1:0] S_GAP    = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             cur_bit;
  logic [WIDTH-1:0] sr_next;
`ifdef TDM_SER_PARITY_EN
  logic             par_bit;
`endif

  // The outgoing bit always sits at one end of the shift register; the
  // register moves toward that end after each bit.
  always_comb begin
    cur_bit = 1'b0;
    sr_next = '0;
    if (LSB_FIRST) begin
      cur_bit = sr[0];
      sr_next = {1'b0, sr[WIDTH-1:1]};
    end else begin
      cur_bit = sr[WIDTH-1];
      sr_next = {sr[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sr        <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      data      <= 1'b0;
      Sel       <= IDLE_CHAN;
      bit_valid <= 1'b0;
      first     <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
`ifdef TDM_SER_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          data      <= 1'b0;
          bit_valid <= 1'b0;
          first     <= 1'b0;
          last      <= 1'b0;
          if (in_valid && in_ready) begin
            // Sel moves only here, never while a bit is on the wire.
            sr       <= in_data;
            Sel      <= in_chan;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= S_SHIFT;
`ifdef TDM_SER_PARITY_EN
            par_bit  <= ^in_data;
`endif
          end
        end

        S_SHIFT: begin
          data      <= cur_bit;
          sr        <= sr_next;
          bit_valid <= 1'b1;
          busy      <= 1'b1;
          first     <= (cnt == '0);
          last      <= 1'b0;
          cnt       <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
`ifdef TDM_SER_PARITY_EN
            state <= S_PARITY;
`else
            last  <= 1'b1;
            state <= S_GAP;
`endif
          end
        end

`ifdef TDM_SER_PARITY_EN
        S_PARITY: begin
          data      <= par_bit;
          bit_valid <= 1'b1;
          first     <= 1'b0;
          last      <= 1'b1;
          state     <= S_GAP;
        end
`endif

        S_GAP: begin
          // busy drops and in_ready rises together with the move to IDLE.
          data      <= 1'b0;
          bit_valid <= 1'b0;
          first     <= 1'b0;
          last      <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_bit_serializer.sv
module tb_tdm_bit_serializer;

`ifdef TDM_SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int W      = 8;
  localparam int PERIOD = W + 2 + PAR;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic [1:0] in_chan;
  logic       in_valid;
  logic       in_ready, data, bit_valid, first, last, busy;
  logic [1:0] Sel;

  logic [3:0] m_din;
  logic [1:0] m_chan;
  logic       m_valid;
  logic       m_ready, m_data, m_bv, m_first, m_last, m_busy;
  logic [1:0] m_sel;

  always #5 clk = ~clk;

  tdm_bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_CHAN(2'b00)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_chan(in_chan),
    .in_valid(in_valid), .in_ready(in_ready), .data(data), .Sel(Sel),
    .bit_valid(bit_valid), .first(first), .last(last), .busy(busy)
  );

  tdm_bit_serializer #(.WIDTH(4), .LSB_FIRST(1'b0), .IDLE_CHAN(2'b00)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_data(m_din), .in_chan(m_chan),
    .in_valid(m_valid), .in_ready(m_ready), .data(m_data), .Sel(m_sel),
    .bit_valid(m_bv), .first(m_first), .last(m_last), .busy(m_busy)
  );

  typedef struct {
    logic       d;
    logic [1:0] s;
    logic       f;
    logic       l;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] w;
    logic [1:0] c;
    bit         b2b;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   bits_seen = 0;
  int   stray = 0;
  logic prev_last = 1'b0;
  logic [1:0] prev_sel = 2'b00;
  logic prev_rst = 1'b0;
  logic acc_edge = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: bit order of an LSB-first word plus optional parity.
  task automatic push_word(input logic [7:0] w, input logic [1:0] c, input int acc);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.d = w[i]; e.s = c; e.f = (i == 0);
      e.l = (PAR == 0) && (i == W - 1);
      e.cyc = acc + 1 + i;
      sbq.push_back(e);
    end
    if (PAR != 0) begin
      e.d = ^w; e.s = c; e.f = 1'b0; e.l = 1'b1; e.cyc = acc + 1 + W;
      sbq.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] w, input logic [1:0] c, output int acc);
    bit ok;
    ok = 1'b0;
    acc = -1;
    in_data = w; in_chan = c; in_valid = 1'b1;
    for (int n = 0; n < 60 && !ok; n++) begin
      if (in_ready) begin
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        push_word(w, c, acc);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("accept_timeout", ok, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sbq.size() > 0; n++) @(negedge clk);
    chk("drain_empty", sbq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    acc_edge = in_valid && in_ready;
  end

  // Scoreboard side: every observed bit is popped and compared.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_last = 1'b0;
    end else begin
      if (prev_last) begin
        chk("gap_bit_valid", bit_valid, 0);
        chk("gap_data", data, 0);
      end
      if (prev_rst && Sel !== prev_sel) chk("sel_change_on_accept", acc_edge, 1);
      if (bit_valid) begin
        bits_seen++;
        if (sbq.size() == 0) begin
          stray++;
          chk("unexpected_bit", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("bit_data", data, mon_e.d);
          chk("bit_sel", Sel, mon_e.s);
          chk("bit_first", first, mon_e.f);
          chk("bit_last", last, mon_e.l);
          chk("bit_cycle", cyc, mon_e.cyc);
          chk("bit_busy", busy, 1);
        end
      end
      prev_last = last;
    end
    prev_sel = Sel;
    prev_rst = rst_n;
  end

  initial begin
    vec_t vecs[6];
    logic exp_m[5];
    logic got_m[5];
    int   acc, prev_acc, mi, base, after;

    vecs[0] = '{8'hFF, 2'b00, 1'b0};
    vecs[1] = '{8'h0F, 2'b11, 1'b1};
    vecs[2] = '{8'h07, 2'b01, 1'b1};
    vecs[3] = '{8'h03, 2'b10, 1'b1};
    vecs[4] = '{8'h80, 2'b11, 1'b0};
    vecs[5] = '{8'h01, 2'b11, 1'b1};
    exp_m = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    got_m = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_chan = '0;
    m_valid = 1'b0; m_din = '0; m_chan = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_sel", Sel, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_first", first, 0);
    chk("rst_last", last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word A5 on channel C.
    send(8'hA5, 2'b10, acc);
    in_valid = 1'b0;
    drain();

    // Table-driven words; b2b records keep in_valid high from the previous one.
    prev_acc = 0;
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].w, vecs[i].c, acc);
      if (vecs[i].b2b) chk("b2b_period", acc - prev_acc, PERIOD);
      prev_acc = acc;
      if (i == 5 || !vecs[i + 1].b2b) begin
        in_valid = 1'b0;
        drain();
      end
    end

    // Backpressure: word offered mid-SHIFT is taken in the first IDLE cycle.
    send(8'h5A, 2'b01, prev_acc);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_busy", busy, 1);
    send(8'h3C, 2'b10, acc);
    chk("bp_accept_cycle", acc - prev_acc, PERIOD);
    in_valid = 1'b0;
    drain();

    // MSB-first, WIDTH=4 instance.
    m_din = 4'b1000; m_chan = 2'b01; m_valid = 1'b1;
    chk("m_ready_idle", m_ready, 1);
    @(posedge clk);
    @(negedge clk);
    m_valid = 1'b0;
    mi = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_bv) begin
        if (mi < 5) got_m[mi] = m_data;
        chk("m_sel", m_sel, 1);
        chk("m_first", m_first, (mi == 0));
        chk("m_last", m_last, (mi == 3 + PAR));
        chk("m_busy", m_busy, 1);
        mi++;
      end
    end
    chk("m_bit_count", mi, 4 + PAR);
    for (int k = 0; k < 4 + PAR; k++) chk("m_bit", got_m[k], exp_m[k]);

    // Reset three bits into a word: dropped with no completion afterwards.
    send(8'hA5, 2'b10, acc);
    in_valid = 1'b0;
    base = bits_seen;
    for (int n = 0; n < 20 && bits_seen < base + 3; n++) @(negedge clk);
    chk("rst_mid_reached", bits_seen - base, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_data", data, 0);
    chk("rst_mid_sel", Sel, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_bit_valid", bit_valid, 0);
    chk("rst_mid_last", last, 0);
    chk("rst_mid_busy", busy, 0);
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    after = stray;
    repeat (15) @(negedge clk);
    chk("post_reset_quiet", stray - after, 0);

    send(8'h96, 2'b11, acc);
    in_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tdm_bit_serializer.md
# tdm_bit_serializer

Upstream feeder for the 1-to-4 bit demultiplexer. It accepts a parallel word tagged with a 2-bit destination channel through a valid/ready handshake, then shifts the word out one bit per clock on `data`. `Sel` holds the channel for the whole word, so the demux steers every bit to one output. Framing strobes let the downstream consumers of A/B/C/D qualify and delimit bits.

## Interface
- `WIDTH`, 8, payload bits per word (2..16)
- `LSB_FIRST`, 1, 1 = bit 0 shifted first, 0 = bit WIDTH-1 first
- `IDLE_CHAN`, 2'b00, `Sel` value driven out of reset
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_data`  in  WIDTH  word to serialize
- `in_chan`  in  2  destination channel (00=A, 01=B, 10=C, 11=D)
- `in_valid`  in  1  word/channel presented
- `in_ready`  out  1  block can accept a word this cycle
- `data`  out  1  serial bit to demux `data` input
- `Sel`  out  2  channel select to demux `Sel` input
- `bit_valid`  out  1  `data` carries a payload (or parity) bit this cycle
- `first`  out  1  first bit of the word
- `last`  out  1  final bit of the word (payload, or parity when enabled)
- `busy`  out  1  word in flight (SHIFT, PARITY or GAP)

## Operation
- All outputs are registered. FSM states: IDLE, SHIFT, PARITY (only when compiled in), GAP.
- IDLE:
  - `in_ready`=1, `data`=0, `bit_valid`=0, `Sel` holds its last value.
  - On `in_valid & in_ready`: latch `in_data` into the shift register, load `Sel`<=`in_chan`, bit counter<=0, go to SHIFT.
- SHIFT:
  - Drive the current bit (LSB or MSB per `LSB_FIRST`) with `bit_valid`=1.
  - `first`=1 when counter==0; counter increments each cycle.
  - At counter==WIDTH-1: `last`=1 if no parity, then go to PARITY or GAP.
- PARITY: drive the even-parity bit (XOR of all payload bits) with `bit_valid`=1 and `last`=1, then go to GAP.
- GAP:
  - One cycle with `data`=0, `bit_valid`=0, `Sel` held.
  - Guarantees the demux outputs all return to 0 between words. Go to IDLE.
- `in_ready` is 0 outside IDLE. `in_valid` asserted while not ready is ignored; the upstream must hold the word until accepted.
- `Sel` changes only on the accept edge. It never changes while `bit_valid`=1, so no glitch bit reaches a wrong channel.
- A channel equal to the previous one still incurs the GAP cycle; no word merging.

## Timing
- Reset (asynchronous assert, synchronous release at the next clock edge):
  - `data`=0, `Sel`=IDLE_CHAN, `bit_valid`=0, `first`=0, `last`=0, `busy`=0, `in_ready`=1, state IDLE.
- Accept at edge N: first bit appears on `data` after edge N+1 (1-cycle latency).
- `busy` rises with the first bit and falls on entry to IDLE.
- Payload occupies WIDTH consecutive cycles, plus 1 parity cycle if enabled.
- Word period, back-to-back: 1 accept + WIDTH + 1 GAP = WIDTH+2 cycles (10 for WIDTH=8); WIDTH+3 with parity.
- WIDTH=2 boundary: `first` and `last` are on different cycles. `first` and `last` never coincide, since WIDTH≥2.
- Reset mid-word: the word is dropped immediately; no partial completion or `last` after release.

## Configuration
- `TDM_SER_PARITY_EN` defined:
  - PARITY state compiled in; one even-parity bit follows the payload on the same `Sel`.
  - `last` marks the parity bit; period becomes WIDTH+3.
- Undefined: no PARITY state or parity logic. `last` marks payload bit WIDTH-1; period is WIDTH+2.

## Test plan
- Reset: assert `rst_n`=0 mid-word (after 3 bits of 8'hA5). Required: `data`=0, `Sel`=00, `in_ready`=1 asynchronously. After release, no further `bit_valid` until a new accept.
- Single word: `in_data`=8'hA5, `in_chan`=2'b10, LSB_FIRST=1. Required: `data` = 1,0,1,0,0,1,0,1 on 8 cycles starting 1 cycle after accept; `Sel`=10 throughout; `first` on bit 0, `last` on bit 7; then 1 GAP cycle with `data`=0.
- Back-to-back: `in_valid` held high with 8'hFF/ch 00, then 8'h0F/ch 11. Required: second accept exactly 10 cycles after the first. `Sel` switches 00→11 only on the second accept edge, never during `bit_valid`.
- Ready backpressure: assert `in_valid` with 8'h3C during SHIFT. Required: word accepted only in the first IDLE cycle; value is unchanged when serialized.
- MSB order: LSB_FIRST=0, WIDTH=4, `in_data`=4'b1000. Required: bit sequence 1,0,0,0.
- Parity (`TDM_SER_PARITY_EN`): 8'h07 → parity bit 1 with `last`; 8'h03 → parity bit 0. Period is 11 cycles.
